mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit; successor to the combinational ALU for the MIPS core.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers.
- Uses a start/busy/done handshake so the core can stall while the unit computes.
- Sits beside the ALU in EX. MFHI/MFLO read hi_out/lo_out directly.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and the
// iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            md_op;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;

  modport master (
    output start, md_op, a_in, b_in,
    input  busy, done, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start, md_op, a_in, b_in,
    output busy, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU,
// MTHI/MTLO into HI/LO. Define MDU_EARLY_OUT_EN to let MUL stop once the multiplier is exhausted.
module mdu_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_iter_if.slave  bus
);
  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [W-1:0]         a_raw_q, a_raw_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 bzero_q, bzero_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg, b_neg;
  logic [W-1:0]         a_mag, b_mag;
  logic [W:0]           mul_sum;
  logic [2*W-1:0]       mul_step;
  logic [W:0]           div_diff;
  logic [2*W-1:0]       div_step;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         quo, rem;
  logic                 last;
`ifdef MDU_EARLY_OUT_EN
  logic [W-1:0]         rem_mask;
  logic [CNT_WIDTH-1:0] shamt;
`endif

  always_comb begin
    // md_op[0] selects the signed variant for both mult and div
    a_neg = bus.md_op[0] & bus.a_in[W-1];
    b_neg = bus.md_op[0] & bus.b_in[W-1];
    a_mag = a_neg ? (~bus.a_in + 1'b1) : bus.a_in;
    b_mag = b_neg ? (~bus.b_in + 1'b1) : bus.b_in;

    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_step = {mul_sum, acc_q[W-1:1]};

    // acc = {partial remainder, dividend bits still to shift in / quotient bits so far}
    div_diff = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    div_step = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem  = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    last = (cnt_q == CNT_WIDTH'(W-1));
  end

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    rem_mask = {W{1'b1}} >> (cnt_q + 1'b1);
    shamt    = CNT_WIDTH'(W-1) - cnt_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          cnt_d = '0;
          case (bus.md_op)
            3'b000, 3'b001: begin
              opnd_d    = a_mag;
              acc_d     = {{W{1'b0}}, b_mag};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              bzero_d   = 1'b0;
              state_d   = S_MUL;
            end
            3'b010, 3'b011: begin
              opnd_d    = b_mag;
              acc_d     = {{W{1'b0}}, a_mag};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_div_d  = 1'b1;
              bzero_d   = (bus.b_in == '0);
              a_raw_d   = bus.a_in;
              state_d   = S_DIV;
            end
            3'b100: begin
              hi_d   = bus.a_in;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = bus.a_in;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_FIN;
        end
`ifdef MDU_EARLY_OUT_EN
        // remaining steps would only shift, so collapse them into one shift
        else if ((mul_step[W-1:0] & rem_mask) == '0) begin
          acc_d   = mul_step >> shamt;
          state_d = S_FIN;
        end
`endif
      end
      S_DIV: begin
        acc_d = div_step;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (bzero_q) begin
          lo_d  = '1;
          hi_d  = a_raw_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (DATA_WIDTH=32) with hand-computed results.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  mdu_iter_if #(.DATA_WIDTH(32)) bus ();

  mdu_iter #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after acceptance until done; optionally pulses start at step 'poke'.
  task automatic wait_done(input int poke, output int lat, output int bcnt, output bit chg);
    logic [31:0] h0, l0;
    h0 = bus.hi_out;
    l0 = bus.lo_out;
    lat = 0; bcnt = 0; chg = 1'b0;
    while (lat < 100) begin
      if (bus.busy) bcnt++;
      if (bus.done) break;
      if (bus.hi_out !== h0 || bus.lo_out !== l0) chg = 1'b1;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.md_op = 3'b100;
        bus.a_in  = 32'hDEAD_BEEF;
        bus.b_in  = 32'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check("done_seen", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int lat, bcnt, nd;
    bit chg;
    bus.start = 1'b0;
    bus.md_op = 3'b000;
    bus.a_in  = '0;
    bus.b_in  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    check("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-1, lat, bcnt, chg);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy", 64'(bcnt), 64'd33);
    check("multu_hold", {63'd0, chg}, 64'd0);
    check("multu_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);
    check("multu_busy_fin", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    check("multu_done_pulse", {63'd0, bus.done}, 64'd0);

    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done(-1, lat, bcnt, chg);
    check("mult_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done(-1, lat, bcnt, chg);
    check("div_lat", 64'(lat), 64'd33);
    check("div_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'b010, 32'd100, 32'd0);
    wait_done(-1, lat, bcnt, chg);
    check("dbz_lat", 64'(lat), 64'd33);
    check("dbz_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0064_FFFF_FFFF);
    check("dbz_flag", {63'd0, bus.div_by_zero}, 64'd1);

    issue(3'b000, 32'd2, 32'd3);
    check("dbz_clear", {63'd0, bus.div_by_zero}, 64'd0);
    wait_done(-1, lat, bcnt, chg);
    check("mul23_hilo", {bus.hi_out, bus.lo_out}, 64'd6);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(5, lat, bcnt, chg);
    check("ovf_lat", 64'(lat), 64'd33);
    check("ovf_hold", {63'd0, chg}, 64'd0);
    check("ovf_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);
    count_done(6, nd);
    check("ovf_no_2nd_done", 64'(nd), 64'd0);

    issue(3'b100, 32'h1234_5678, 32'd0);
    check("mthi_done", {63'd0, bus.done}, 64'd1);
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    check("mthi_hi", {32'd0, bus.hi_out}, 64'h1234_5678);
    issue(3'b101, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_done", {63'd0, bus.done}, 64'd1);
    check("mtlo_hilo", {bus.hi_out, bus.lo_out}, 64'h1234_5678_9ABC_DEF0);

    issue(3'b110, 32'h5555_5555, 32'd1);
    check("noop_busy", {63'd0, bus.busy}, 64'd0);
    count_done(5, nd);
    check("noop_done", 64'(nd + int'(bus.busy)), 64'd0);
    check("noop_hilo", {bus.hi_out, bus.lo_out}, 64'h1234_5678_9ABC_DEF0);

    issue(3'b000, 32'd5, 32'd1);
    wait_done(-1, lat, bcnt, chg);
    check("early_lat", 64'(lat), 64'(EARLY_LAT));
    check("early_hilo", {bus.hi_out, bus.lo_out}, 64'd5);
    issue(3'b000, 32'd3, 32'h8000_0000);
    wait_done(-1, lat, bcnt, chg);
    check("msb_lat", 64'(lat), 64'd33);
    check("msb_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0001_8000_0000);

    issue(3'b010, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, nd);
    check("abort_no_done", 64'(nd), 64'd0);

    issue(3'b010, 32'd1000, 32'd3);
    wait_done(-1, lat, bcnt, chg);
    check("divu_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0001_0000_014D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
